// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester (core / loader) arbiter for a single-port data
//               memory. Each access takes three cycles: IDLE decision, ISSUE
//               (memory strobe) and DONE (ready pulse + read data). The core
//               normally wins, but a loader that has lost STARVE_MAX times in
//               a row is forced through.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_ready,
  output logic [DW-1:0] core_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ready,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner,
  output logic [3:0]    starve_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_CORE   = 2'b01;
  localparam logic [1:0] OWN_LDR    = 2'b10;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [3:0]      starve_q, starve_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            core_wins;
  logic            in_issue;
  logic            in_done;

  // State and latched-access registers; reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state, arbitration and starvation bookkeeping
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    // The loader only overrides the core once it has been starved long enough
    core_wins = core_req && !(ldr_req && (starve_q == STARVE_LIM));
    case (state_q)
      IDLE: begin
        owner_d = OWN_NONE;
        if (core_req || ldr_req) begin
          state_d = ISSUE;
          if (core_wins) begin
            owner_d = OWN_CORE;
            we_d    = core_we;
            addr_d  = core_addr;
            wdata_d = core_wdata;
            if (ldr_req && (starve_q < STARVE_LIM)) begin
              starve_d = starve_q + 4'd1;
            end
          end else begin
            owner_d  = OWN_LDR;
            we_d     = ldr_we;
            addr_d   = ldr_addr;
            wdata_d  = ldr_wdata;
            starve_d = 4'd0;
          end
        end
      end
      ISSUE: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Memory strobe and per-requester completion outputs, all decoded from flops
  always_comb begin
    in_issue   = (state_q == ISSUE);
    in_done    = (state_q == DONE);
    mem_en     = in_issue;
    mem_we     = in_issue && we_q;
    mem_addr   = in_issue ? addr_q  : '0;
    mem_wdata  = in_issue ? wdata_q : '0;
    core_ready = in_done && (owner_q == OWN_CORE);
    ldr_ready  = in_done && (owner_q == OWN_LDR);
    core_rdata = (core_ready && !we_q) ? mem_rdata : '0;
    ldr_rdata  = (ldr_ready  && !we_q) ? mem_rdata : '0;
    owner      = owner_q;
    starve_cnt = starve_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A transaction-level
//               reference (grant queue of one, plain array memory) predicts
//               every output each cycle; directed scenarios are followed by
//               randomized core/loader traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SMAX = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_ready;
  logic [DW-1:0] core_rdata;
  logic          ldr_req, ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_ready;
  logic [DW-1:0] ldr_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;
  logic [3:0]    starve_cnt;

  // Harness memory seen by the DUT, and the reference's own view of memory
  logic [DW-1:0] tb_mem  [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  // Reference: cycles since grant (0 = free), the granted access, loss count
  int            slot;
  int            who;          // 1 = core, 2 = loader
  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  logic [DW-1:0] rd_val;
  int            starve;
  int            peak;

  int errors = 0;
  int checks = 0;

  // Captured memory strobes for the harness memory
  logic          s_en, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ready (core_ready),
    .core_rdata (core_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_ready  (ldr_ready),
    .ldr_rdata  (ldr_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .owner      (owner),
    .starve_cnt (starve_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference update for one rising edge, using the inputs present at the edge
  task automatic ref_edge();
    if (!reset) begin
      slot   = 0;
      starve = 0;
    end else if (slot == 0) begin
      if (core_req || ldr_req) begin
        if (core_req && !(ldr_req && starve == SMAX)) begin
          who = 1; t_we = core_we; t_addr = core_addr; t_wdata = core_wdata;
          if (ldr_req) starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
        end else begin
          who = 2; t_we = ldr_we; t_addr = ldr_addr; t_wdata = ldr_wdata;
          starve = 0;
        end
        slot = 1;
      end
    end else if (slot == 1) begin
      // The memory operation takes effect on the edge that ends the strobe
      if (t_we) ref_mem[t_addr] = t_wdata;
      else      rd_val = ref_mem[t_addr];
      slot = 2;
    end else begin
      slot = 0;
    end
  endtask

  task automatic check_outputs();
    chk("mem_en",     {31'd0, mem_en},    {31'd0, slot == 1});
    chk("mem_we",     {31'd0, mem_we},    {31'd0, slot == 1 && t_we});
    chk("mem_addr",   {22'd0, mem_addr},  (slot == 1) ? {22'd0, t_addr} : 32'd0);
    chk("mem_wdata",  mem_wdata,          (slot == 1) ? t_wdata : 32'd0);
    chk("owner",      {30'd0, owner},     (slot == 0) ? 32'd0 : who);
    chk("core_ready", {31'd0, core_ready}, {31'd0, slot == 2 && who == 1});
    chk("ldr_ready",  {31'd0, ldr_ready},  {31'd0, slot == 2 && who == 2});
    chk("core_rdata", core_rdata, (slot == 2 && who == 1 && !t_we) ? rd_val : 32'd0);
    chk("ldr_rdata",  ldr_rdata,  (slot == 2 && who == 2 && !t_we) ? rd_val : 32'd0);
    chk("starve_cnt", {28'd0, starve_cnt}, starve);
  endtask

  // One clock: harness memory acts on the strobes captured mid-cycle
  task automatic step();
    @(negedge clk);
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    @(posedge clk);
    if (s_en && s_we)  tb_mem[s_addr] = s_wdata;
    if (s_en && !s_we) mem_rdata = tb_mem[s_addr];
    #1;
    ref_edge();
    check_outputs();
    if (32'(starve_cnt) > peak) peak = 32'(starve_cnt);
  endtask

  task automatic new_core();
    core_we    = 1'($urandom_range(1, 0));
    core_addr  = AW'($urandom_range(15, 0));
    core_wdata = $urandom;
  endtask

  task automatic new_ldr();
    ldr_we    = 1'($urandom_range(1, 0));
    ldr_addr  = AW'($urandom_range(15, 0));
    ldr_wdata = $urandom;
  endtask

  // Masters hold a request until its ready, then drop it or issue another
  task automatic drive_masters(input int p_req, input bit keep);
    if (core_req) begin
      if (slot == 2 && who == 1) begin
        if (!keep && $urandom_range(1, 0) == 0) core_req = 1'b0;
        else new_core();
      end
    end else if (int'($urandom_range(99, 0)) < p_req) begin
      core_req = 1'b1; new_core();
    end
    if (ldr_req) begin
      if (slot == 2 && who == 2) begin
        if (!keep && $urandom_range(1, 0) == 0) ldr_req = 1'b0;
        else new_ldr();
      end
    end else if (int'($urandom_range(99, 0)) < p_req) begin
      ldr_req = 1'b1; new_ldr();
    end
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ldr_req  = 1'b0; ldr_we  = 1'b0; ldr_addr  = '0; ldr_wdata  = '0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      tb_mem[i]  = (32'(i) * 32'h9e3779b9) ^ 32'h00005a5a;
      ref_mem[i] = (32'(i) * 32'h9e3779b9) ^ 32'h00005a5a;
    end
    tb_mem[10]  = 32'h428a2f98;
    ref_mem[10] = 32'h428a2f98;
    mem_rdata = '0;
    slot = 0; who = 0; t_we = 0; t_addr = '0; t_wdata = '0; rd_val = '0;
    starve = 0; peak = 0;
    idle_inputs();
    reset = 1'b0;
    repeat (3) step();
    #1 reset = 1'b1;

    // Lone core read of a preloaded word
    core_req = 1'b1; core_we = 1'b0; core_addr = AW'(10);
    step();
    chk("r031_mem_en_c2", {31'd0, mem_en}, 32'd1);
    chk("r031_owner_c2", {30'd0, owner}, 32'd1);
    step();
    chk("r031_rdata_c3", core_rdata, 32'h428a2f98);
    core_req = 1'b0;
    step();

    // Loader write then core read of the same word
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = AW'(100); ldr_wdata = 32'h68656c6c;
    repeat (3) step();
    ldr_req = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = AW'(100);
    repeat (2) step();
    chk("r032_rdata", core_rdata, 32'h68656c6c);
    core_req = 1'b0;
    step();

    // Simultaneous requests: core first, loader next
    core_req = 1'b1; core_we = 1'b0; core_addr = AW'(1);
    ldr_req  = 1'b1; ldr_we  = 1'b0; ldr_addr  = AW'(2);
    step();
    chk("r033_starve1", {28'd0, starve_cnt}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      if (slot == 2 && who == 1) core_req = 1'b0;
      if (slot == 2 && who == 2) ldr_req  = 1'b0;
      step();
    end
    chk("r033_starve0", {28'd0, starve_cnt}, 32'd0);
    idle_inputs();
    step();

    // Continuous contention: starvation forces the loader through
    peak = 0;
    core_req = 1'b1; new_core();
    ldr_req  = 1'b1; new_ldr();
    for (int c = 0; c < 70; c++) begin
      step();
      drive_masters(100, 1'b1);
    end
    chk("r034_peak", peak, SMAX);
    idle_inputs();
    repeat (3) step();
    starve = 32'(starve_cnt) == starve ? starve : starve;

    // Reset during the strobe of a core write
    core_req = 1'b1; core_we = 1'b1; core_addr = AW'(5); core_wdata = 32'hdeadbeef;
    step();
    #2 reset = 1'b0;
    #1;
    chk("r035_mem_en", {31'd0, mem_en}, 32'd0);
    chk("r035_mem_we", {31'd0, mem_we}, 32'd0);
    chk("r035_owner",  {30'd0, owner},  32'd0);
    core_req = 1'b0;
    repeat (2) step();
    #1 reset = 1'b1;
    repeat (3) step();
    chk("r035_starve", {28'd0, starve_cnt}, 32'd0);
    core_req = 1'b1; core_we = 1'b0; core_addr = AW'(5);
    repeat (2) step();
    chk("r035_unwritten", core_rdata, (32'd5 * 32'h9e3779b9) ^ 32'h00005a5a);
    core_req = 1'b0;
    step();

    // Quiet period
    for (int c = 0; c < 20; c++) step();

    // Randomized traffic at several request intensities
    for (int c = 0; c < 600; c++) begin
      drive_masters((c < 200) ? 30 : (c < 400) ? 70 : 100, 1'b0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 10, word-address width (1024-word data memory).
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter STARVE_MAX, default 8, consecutive loader losses before the loader is forced a grant.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 core_req  input  1  core access request, held until core_ready.
REQ-007 core_we  input  1  core write enable (1 = write, 0 = read).
REQ-008 core_addr  input  AW  core word address.
REQ-009 core_wdata  input  DW  core write data.
REQ-010 core_ready  output  1  one-cycle core completion pulse.
REQ-011 core_rdata  output  DW  core read data, valid only with core_ready.
REQ-012 ldr_req, ldr_we, ldr_addr, ldr_wdata  input  1/1/AW/DW  loader (constant/message preload) request, same semantics as core_*.
REQ-013 ldr_ready, ldr_rdata  output  1/DW  loader completion pulse and read data.
REQ-014 mem_en, mem_we  output  1/1  single-port data memory enable and write enable.
REQ-015 mem_addr, mem_wdata  output  AW/DW  memory address and write data.
REQ-016 mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we=0.
REQ-017 owner  output  2  current grant: 00 none, 01 core, 10 loader.
REQ-018 starve_cnt  output  4  loader starvation count.

Function
REQ-019 FSM states: IDLE, ISSUE, DONE; each access takes exactly 3 cycles (IDLE decision, ISSUE, DONE).
REQ-020 IDLE: if any req is high, register the winner into owner, latch its we/addr/wdata, go to ISSUE; else stay in IDLE with owner=00.
REQ-021 Arbitration: core wins when both request, unless starve_cnt == STARVE_MAX, in which case the loader wins.
REQ-022 starve_cnt increments (saturating at STARVE_MAX) on each core grant made while ldr_req is high, clears to 0 on each loader grant, and holds otherwise.
REQ-023 ISSUE: mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values; next state DONE unconditionally.
REQ-024 DONE: owner's ready=1 for exactly one cycle; for reads owner's rdata=mem_rdata, for writes rdata=0; next state IDLE.
REQ-025 Outside ISSUE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; non-owner ready=0, rdata=0.
REQ-026 Request inputs are sampled only in IDLE; changes during ISSUE/DONE have no effect on the in-flight access.
REQ-027 A req still high in the IDLE cycle after its ready pulse is treated as a new request.
REQ-028 Never more than one ready asserted in any cycle; never more than one mem_en per access.

Reset
REQ-029 reset low forces IDLE, owner=00, starve_cnt=0, latched fields=0, and all outputs to 0 immediately (asynchronously).
REQ-030 Reset during ISSUE aborts the access: mem_en/mem_we drop immediately, no ready is issued for it, and the first cycle after reset release is IDLE.

Verification
REQ-031 mem[10]=0x428a2f98; core read addr 10 alone -> mem_en high in cycle 2, core_ready with core_rdata=0x428a2f98 in cycle 3, owner=01 during cycles 2-3.
REQ-032 Loader write 0x68656c6c to addr 100, then core read addr 100 -> ldr_ready in cycle 3 with ldr_rdata=0; core_ready in cycle 6 with core_rdata=0x68656c6c.
REQ-033 core_req and ldr_req rise together, starve_cnt=0 -> core served first (starve_cnt=1), loader served in the next access (starve_cnt back to 0).
REQ-034 core_req and ldr_req held high continuously, STARVE_MAX=8 -> 8 core grants (starve_cnt counts 1..8), then loader grant, then core resumes; pattern repeats.
REQ-035 Reset asserted during ISSUE of a core write to addr 5 -> mem_we low in the same cycle, no core_ready, owner=00, starve_cnt=0 after release.
REQ-036 No requests for 20 cycles -> mem_en, both ready outputs and owner remain 0 throughout.
